balance_pid: RTL and testbench

//  Balance-loop PID controller, upstream of segway_math. Consumes filtered pitch
//  and pitch rate from the inertial interface and produces the signed 12-bit
//  PID_cntrl effort. Also produces the 8-bit soft-start ramp ss_tmr, which

---
 rtl/balance_pid.sv | 111 +++++++++++
 tb/tb_balance_pid.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/balance_pid.sv
// Balance-loop PID controller: saturated P/I/D effort from pitch and pitch rate,
// plus the soft-start torque ramp consumed by segway_math.
module balance_pid #(
    parameter logic signed [4:0] P_COEFF  = 5'sd9,
    parameter bit                FAST_SIM = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] ptch_rt,
    input  logic               pwr_up,
    input  logic               rider_off,
    output logic signed [11:0] PID_cntrl,
    output logic        [7:0]  ss_tmr
);

    localparam logic [26:0] SS_STEP = FAST_SIM ? 27'd256 : 27'd1;

    function automatic logic signed [9:0] sat10(input logic signed [15:0] v);
        logic signed [9:0] r;
        if (v > 16'sd511) begin
            r = 10'sd511;
        end else if (v < -16'sd512) begin
            r = -10'sd512;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
        logic signed [11:0] r;
        if (v > 16'sd2047) begin
            r = 12'sd2047;
        end else if (v < -16'sd2048) begin
            r = -12'sd2048;
        end else begin
            r = v[11:0];
        end
        return r;
    endfunction

    logic signed [9:0]  err_sat_s;
    logic signed [14:0] p_term_s;
    logic signed [14:0] i_term_s;
    logic signed [15:0] d_term_s;
    logic signed [15:0] sum_s;
    logic signed [17:0] err_ext_s;
    logic signed [17:0] integ_sum_s;
    logic               integ_ovf_s;
    logic               ss_full_s;

    logic signed [17:0] integ_q, integ_d;
    logic signed [11:0] pid_q, pid_d;
    logic        [26:0] ss_cnt_q, ss_cnt_d;

    // PID datapath: error saturation, the three terms and the clamped sum
    always_comb begin
        err_sat_s = sat10(ptch);
        p_term_s  = {{5{err_sat_s[9]}}, err_sat_s} * {{10{P_COEFF[4]}}, P_COEFF};
        i_term_s  = {{3{integ_q[17]}}, integ_q[17:6]};
        // Arithmetic shift keeps small negative rates (e.g. -1) at -1, not large positive
        d_term_s  = 16'sd0 - (ptch_rt >>> 6);
        sum_s     = {p_term_s[14], p_term_s} + {i_term_s[14], i_term_s} + d_term_s;
        pid_d     = sat12(sum_s);
    end

    // Integrator next state: clear on rider_off, accumulate on vld unless it would overflow
    always_comb begin
        err_ext_s   = {{8{err_sat_s[9]}}, err_sat_s};
        integ_sum_s = integ_q + err_ext_s;
        integ_ovf_s = (integ_q[17] == err_ext_s[17]) && (integ_sum_s[17] != integ_q[17]);
        if (rider_off) begin
            integ_d = 18'sd0;
        end else if (vld && !integ_ovf_s) begin
            integ_d = integ_sum_s;
        end else begin
            integ_d = integ_q;
        end
    end

    // Soft-start counter next state: cleared while powered down, saturates at full scale
    always_comb begin
        ss_full_s = &ss_cnt_q[26:19];
        if (!pwr_up) begin
            ss_cnt_d = 27'd0;
        end else if (!ss_full_s) begin
            ss_cnt_d = ss_cnt_q + SS_STEP;
        end else begin
            ss_cnt_d = ss_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q  <= 18'sd0;
            pid_q    <= 12'sd0;
            ss_cnt_q <= 27'd0;
        end else begin
            integ_q  <= integ_d;
            pid_q    <= pid_d;
            ss_cnt_q <= ss_cnt_d;
        end
    end

    assign PID_cntrl = pid_q;
    assign ss_tmr    = ss_cnt_q[26:19];

endmodule

// File: tb/tb_balance_pid.sv
// Directed self-checking bench for balance_pid with FAST_SIM=1.
module tb_balance_pid;

    logic               clk;
    logic               rst_n;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] PID_cntrl;
    logic        [7:0]  ss_tmr;

    int n_checks;
    int n_fail;

    balance_pid #(.P_COEFF(5'sd9), .FAST_SIM(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .PID_cntrl (PID_cntrl),
        .ss_tmr    (ss_tmr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = 1'b0; ptch = 16'sh0; ptch_rt = 16'sh0;
        pwr_up = 1'b0; rider_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (PID_cntrl !== 12'h000) begin
            n_fail++; $display("FAIL reset_pid: got %h expected %h", PID_cntrl, 12'h000);
        end
        n_checks++;
        if (ss_tmr !== 8'h00) begin
            n_fail++; $display("FAIL reset_ss: got %h expected %h", ss_tmr, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h000) begin
            n_fail++; $display("FAIL idle_pid: got %h expected %h", PID_cntrl, 12'h000);
        end
    endtask

    task automatic test_prop_deriv();
        logic [15:0] tp [12];
        logic [15:0] tr [12];
        logic [11:0] te [12];
        tp = '{16'h0040, 16'h7FFF, 16'h8000, 16'h00E3, 16'hFFC0, 16'hFE00,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0039};
        tr = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0400, 16'hFC00, 16'hFFFF, 16'h003F, 16'h0400, 16'h8000};
        te = '{12'h240, 12'h7FF, 12'h800, 12'h7FB, 12'hDC0, 12'h800,
               12'hFF0, 12'h010, 12'h001, 12'h000, 12'h230, 12'h401};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ptch = tp[i]; ptch_rt = tr[i];
            tick();
            n_checks++;
            if (PID_cntrl !== te[i]) begin
                n_fail++;
                $display("FAIL pd_vec%0d: ptch=%h ptch_rt=%h got %h expected %h",
                         i, tp[i], tr[i], PID_cntrl, te[i]);
            end
        end
        // Output must not move before the next edge
        @(negedge clk);
        ptch = 16'sh0040; ptch_rt = 16'sh0;
        #1;
        n_checks++;
        if (PID_cntrl !== 12'h401) begin
            n_fail++; $display("FAIL latency: got %h expected %h", PID_cntrl, 12'h401);
        end
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h240) begin
            n_fail++; $display("FAIL latency_after: got %h expected %h", PID_cntrl, 12'h240);
        end
    endtask

    task automatic test_integ();
        @(negedge clk);
        ptch = 16'sh0040; ptch_rt = 16'sh0; vld = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h260) begin
            n_fail++; $display("FAIL integ_32: got %h expected %h", PID_cntrl, 12'h260);
        end
        @(negedge clk);
        vld = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h280) begin
            n_fail++; $display("FAIL integ_64: got %h expected %h", PID_cntrl, 12'h280);
        end
        @(negedge clk);
        vld = 1'b1; rider_off = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0; rider_off = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h240) begin
            n_fail++; $display("FAIL integ_clear: got %h expected %h", PID_cntrl, 12'h240);
        end
        @(negedge clk);
        ptch = -16'sd64; vld = 1'b1;
        repeat (64) @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'hD80) begin
            n_fail++; $display("FAIL integ_neg: got %h expected %h", PID_cntrl, 12'hD80);
        end
        @(negedge clk);
        rider_off = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rider_off = 1'b0;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        ptch = 16'sh7FFF; ptch_rt = 16'sh0; vld = 1'b1;
        repeat (600) @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h7FF) begin
            n_fail++; $display("FAIL ovf_pid: got %h expected %h", PID_cntrl, 12'h7FF);
        end
        @(negedge clk);
        ptch = 16'sh0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h7FC) begin
            n_fail++; $display("FAIL ovf_pos_hold: got %h expected %h", PID_cntrl, 12'h7FC);
        end
        @(negedge clk);
        ptch = 16'sh8000; vld = 1'b1;
        repeat (600) @(posedge clk);
        @(negedge clk);
        vld = 1'b0; ptch = 16'sh0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h804) begin
            n_fail++; $display("FAIL ovf_neg_hold: got %h expected %h", PID_cntrl, 12'h804);
        end
        @(negedge clk);
        rider_off = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rider_off = 1'b0;
        tick();
        n_checks++;
        if (PID_cntrl !== 12'h000) begin
            n_fail++; $display("FAIL ovf_clear: got %h expected %h", PID_cntrl, 12'h000);
        end
    endtask

    task automatic test_soft_start();
        @(negedge clk);
        pwr_up = 1'b1;
        repeat (2047) @(posedge clk);
        #1;
        n_checks++;
        if (ss_tmr !== 8'h00) begin
            n_fail++; $display("FAIL ss_2047: got %h expected %h", ss_tmr, 8'h00);
        end
        tick();
        n_checks++;
        if (ss_tmr !== 8'h01) begin
            n_fail++; $display("FAIL ss_2048: got %h expected %h", ss_tmr, 8'h01);
        end
        repeat (2048) @(posedge clk);
        #1;
        n_checks++;
        if (ss_tmr !== 8'h02) begin
            n_fail++; $display("FAIL ss_4096: got %h expected %h", ss_tmr, 8'h02);
        end
        @(negedge clk);
        pwr_up = 1'b0;
        tick();
        n_checks++;
        if (ss_tmr !== 8'h00) begin
            n_fail++; $display("FAIL ss_pwr_down: got %h expected %h", ss_tmr, 8'h00);
        end
        @(negedge clk);
        pwr_up = 1'b1; ptch = 16'sh0040;
        repeat (3000) @(posedge clk);
        #1;
        n_checks++;
        if (ss_tmr !== 8'h01 || PID_cntrl !== 12'h240) begin
            n_fail++; $display("FAIL ss_restart: ss_tmr=%h pid=%h expected 01 240", ss_tmr, PID_cntrl);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (PID_cntrl !== 12'h000 || ss_tmr !== 8'h00) begin
            n_fail++; $display("FAIL async_reset: pid=%h ss_tmr=%h expected 000 00", PID_cntrl, ss_tmr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_prop_deriv();
        test_integ();
        test_overflow();
        test_soft_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
